// File: rtl/io_pkg.sv
// Shared constants for the I/O register bank: status word bit positions
// and the default mailbox/status slot indices.
package io_pkg;
    localparam int STAT_RXV  = 0;
    localparam int STAT_OVR  = 1;
    localparam int STAT_TXV  = 2;
    localparam int STAT_DROP = 3;

    localparam int DEF_RX_IDX   = 0;
    localparam int DEF_TX_IDX   = 1;
    localparam int DEF_STAT_IDX = 2;
endpackage

// File: rtl/io_reg_cell.sv
// Single T-bit storage slot with synchronous active-high reset and load enable.
module io_reg_cell #(
    parameter int T = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_we,
    input  logic [T-1:0] i_d,
    output logic [T-1:0] o_q
);
    logic [T-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_q <= '0;
        else if (i_we)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/io_reg_bank.sv
// Address-decoded I/O register bank with RX/TX mailboxes, a W1C status word,
// a registered read port and a flat view of all slots for legacy consumers.
module io_reg_bank
    import io_pkg::*;
#(
    parameter int R        = 4,
    parameter int T        = 8,
    parameter int N        = 2,
    parameter int RX_IDX   = DEF_RX_IDX,
    parameter int TX_IDX   = DEF_TX_IDX,
    parameter int STAT_IDX = DEF_STAT_IDX
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [N-1:0]   wr_addr,
    input  logic [T-1:0]   wr_data,
    input  logic           rd_en,
    input  logic [N-1:0]   rd_addr,
    output logic [T-1:0]   rd_data,
    output logic           rd_valid,
    input  logic [T-1:0]   rx_data,
    input  logic           rx_strobe,
    output logic [T-1:0]   tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [R*T-1:0] regs_flat
);
    logic [T-1:0] w_slots [R];
    logic [T-1:0] w_stat;
    logic [T-1:0] w_rd_word;
    logic         w_wr_tx;
    logic         w_wr_stat;
    logic         w_rd_rx;
    logic         w_ovr_set;
    logic         w_drop_set;

    logic         r_rx_valid;
    logic         r_overrun;
    logic         r_tx_valid;
    logic         r_tx_drop;
    logic [T-1:0] r_rd_data;
    logic         r_rd_valid;

    assign w_wr_tx    = wr_en && (wr_addr == N'(TX_IDX));
    assign w_wr_stat  = wr_en && (wr_addr == N'(STAT_IDX));
    assign w_rd_rx    = rd_en && (rd_addr == N'(RX_IDX));
    // A read of RX in the same cycle consumes the old byte, so no overrun.
    assign w_ovr_set  = rx_strobe && r_rx_valid && !w_rd_rx;
    assign w_drop_set = w_wr_tx && r_tx_valid;

    always_comb begin
        w_stat            = '0;
        w_stat[STAT_RXV]  = r_rx_valid;
        w_stat[STAT_OVR]  = r_overrun;
        w_stat[STAT_TXV]  = r_tx_valid;
        w_stat[STAT_DROP] = r_tx_drop;
    end

    for (genvar g = 0; g < R; g++) begin : g_slot
        if (g == STAT_IDX) begin : g_stat
            assign w_slots[g] = w_stat;
        end else begin : g_cell
            logic         w_we;
            logic [T-1:0] w_d;
            if (g == RX_IDX) begin : g_rx
                assign w_we = rx_strobe;
                assign w_d  = rx_data;
            end else if (g == TX_IDX) begin : g_tx
                assign w_we = w_wr_tx && !r_tx_valid;
                assign w_d  = wr_data;
            end else begin : g_gp
                assign w_we = wr_en && (wr_addr == N'(g));
                assign w_d  = wr_data;
            end
            io_reg_cell #(.T(T)) u_cell (
                .i_clk (clk),
                .i_rst (rst),
                .i_we  (w_we),
                .i_d   (w_d),
                .o_q   (w_slots[g])
            );
        end
        assign regs_flat[g*T +: T] = w_slots[g];
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < R; i++) begin
            if (rd_addr == N'(i))
                w_rd_word = w_slots[i];
        end
    end

    // Set beats a simultaneous W1C clear on both sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_drop  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (rx_strobe)
                r_rx_valid <= 1'b1;
            else if (w_rd_rx)
                r_rx_valid <= 1'b0;

            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (w_wr_stat && wr_data[STAT_OVR])
                r_overrun <= 1'b0;

            if (w_wr_tx && !r_tx_valid)
                r_tx_valid <= 1'b1;
            else if (r_tx_valid && tx_ready)
                r_tx_valid <= 1'b0;

            if (w_drop_set)
                r_tx_drop <= 1'b1;
            else if (w_wr_stat && wr_data[STAT_DROP])
                r_tx_drop <= 1'b0;

            r_rd_valid <= rd_en;
            if (rd_en)
                r_rd_data <= w_rd_word;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign tx_data  = w_slots[TX_IDX];
    assign tx_valid = r_tx_valid;
endmodule

// File: tb/tb_io_reg_bank.sv
// Directed bench for io_reg_bank: write/read path, TX and RX mailboxes,
// status W1C behaviour and reset during an open handshake.
module tb_io_reg_bank;
    localparam int R = 4;
    localparam int T = 8;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [N-1:0]   wr_addr;
    logic [T-1:0]   wr_data;
    logic           rd_en;
    logic [N-1:0]   rd_addr;
    logic [T-1:0]   rd_data;
    logic           rd_valid;
    logic [T-1:0]   rx_data;
    logic           rx_strobe;
    logic [T-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [R*T-1:0] regs_flat;

    int n_cmp = 0;
    int n_err = 0;

    io_reg_bank #(.R(R), .T(T), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = N'(a); wr_data = T'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = N'(a);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic strobe(input int d);
        rx_strobe = 1'b1; rx_data = T'(d);
        tick();
        rx_strobe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
        rx_data = 0; rx_strobe = 0; tx_ready = 0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_flat", regs_flat, 0);

        // GP slot write/read, out-of-range access
        wr(3, 8'hA5);
        check("gp_flat", 32'(regs_flat[31:24]), 32'hA5);
        rd_en = 1'b1; rd_addr = 3'd3;
        check("rd_valid_pre", 32'(rd_valid), 0);
        tick(); rd_en = 1'b0;
        check("rd_gp_data", 32'(rd_data), 32'hA5);
        check("rd_gp_valid", 32'(rd_valid), 1);
        tick();
        check("rd_valid_drop", 32'(rd_valid), 0);
        check("rd_data_hold", 32'(rd_data), 32'hA5);
        rd(5);
        check("rd_oor_data", 32'(rd_data), 0);
        check("rd_oor_valid", 32'(rd_valid), 1);
        wr(4, 8'hFF);
        check("wr_oor_ignored", regs_flat, 32'hA5000000);
        wr(0, 8'h3C);
        check("wr_rx_ignored", 32'(regs_flat[7:0]), 0);

        // TX mailbox
        wr(1, 8'h41);
        for (int i = 0; i < 3; i++) begin
            check("tx_valid_hold", 32'(tx_valid), 1);
            check("tx_data_hold", 32'(tx_data), 32'h41);
            tick();
        end
        wr(1, 8'h42);
        check("tx_drop_keep", 32'(tx_data), 32'h41);
        check("stat_drop", 32'(regs_flat[23:16]), 32'h0C);
        rd(2);
        check("rd_stat_drop", 32'(rd_data), 32'h0C);
        wr(2, 8'h08);
        check("stat_drop_clr", 32'(regs_flat[23:16]), 32'h04);
        tx_ready = 1'b1;
        wr(1, 8'h43);
        tx_ready = 1'b0;
        check("tx_xfer_valid", 32'(tx_valid), 0);
        check("tx_xfer_slot", 32'(regs_flat[15:8]), 32'h41);
        check("stat_drop_xfer", 32'(regs_flat[23:16]), 32'h08);
        wr(2, 8'hF7);
        check("stat_w1c_other", 32'(regs_flat[23:16]), 32'h08);
        wr(2, 8'h08);
        check("stat_clear", 32'(regs_flat[23:16]), 0);

        // RX mailbox
        strobe(8'h55);
        rd(2);
        check("rd_stat_rxv", 32'(rd_data), 32'h01);
        rd(0);
        check("rd_rx_data", 32'(rd_data), 32'h55);
        rd(2);
        check("rd_stat_rxclr", 32'(rd_data), 0);

        strobe(8'h11);
        strobe(8'h22);
        check("stat_ovr", 32'(regs_flat[23:16]), 32'h03);
        check("rx_overwrite", 32'(regs_flat[7:0]), 32'h22);
        wr(2, 8'h02);
        check("stat_ovr_clr", 32'(regs_flat[23:16]), 32'h01);

        rd(0);
        strobe(8'h66);
        check("stat_rx66", 32'(regs_flat[23:16]), 32'h01);
        rd_en = 1'b1; rd_addr = 3'd0;
        strobe(8'h77);
        rd_en = 1'b0;
        check("rd_rx_race_data", 32'(rd_data), 32'h66);
        check("rx_race_slot", 32'(regs_flat[7:0]), 32'h77);
        check("rx_race_stat", 32'(regs_flat[23:16]), 32'h01);

        // overrun set beats simultaneous W1C clear
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h02;
        strobe(8'h88);
        wr_en = 1'b0;
        check("ovr_set_wins", 32'(regs_flat[23:16]), 32'h03);

        // reset with open TX handshake and pending RX
        wr(1, 8'h99);
        check("pre_rst_stat", 32'(regs_flat[23:16]), 32'h07);
        rst = 1'b1; tx_ready = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_tx_valid", 32'(tx_valid), 0);
        check("rst2_rd_data", 32'(rd_data), 0);
        check("rst2_rd_valid", 32'(rd_valid), 0);
        check("rst2_flat", regs_flat, 0);
        tick();
        tx_ready = 1'b0;
        check("post_rst_tx_valid", 32'(tx_valid), 0);
        check("post_rst_flat", regs_flat, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
